// File: rtl/demux_1_to_8_buf.sv
// 1-to-8 demultiplexer with a one-deep holding register per output channel.
// Destination is in_sel or an internal round-robin pointer; transfers use valid/ready handshakes.
module demux_1_to_8_buf #(
   parameter int DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [2:0]            in_sel,
   input  logic                  auto_mode,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [8*DATA_W-1:0]   out_data,
   output logic [7:0]            out_valid,
   input  logic [7:0]            out_ready,
   output logic [2:0]            rr_ptr,
   output logic [15:0]           acc_count
);

   logic [7:0][DATA_W-1:0] data_q, data_d;
   logic [7:0]             valid_q, valid_d;
   logic [2:0]             rr_ptr_q, rr_ptr_d;
   logic [15:0]            acc_count_q, acc_count_d;

   logic [2:0]             dst;
   logic                   in_xfer;

   // A full channel can still accept when its consumer drains it at the same edge.
   assign dst      = auto_mode ? rr_ptr_q : in_sel;
   assign in_ready = !valid_q[dst] || out_ready[dst];
   assign in_xfer  = in_valid && in_ready;

   // NOTE: every always_comb output gets a default first so no path infers a latch;
   // combinational logic uses blocking '=' so later lines see earlier updates.
   always_comb begin
      valid_d     = valid_q & ~out_ready;
      data_d      = data_q;
      rr_ptr_d    = rr_ptr_q;
      acc_count_d = acc_count_q;
      if (in_xfer) begin
         valid_d[dst] = 1'b1;
         data_d[dst]  = in_data;
         if (auto_mode) begin
            rr_ptr_d = rr_ptr_q + 3'd1;
         end
         if (acc_count_q != 16'hFFFF) begin
            acc_count_d = acc_count_q + 16'd1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
   // NOTE: the lane registers are reset too, since out_data must read zero while rst_n is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q      <= '0;
         valid_q     <= '0;
         rr_ptr_q    <= '0;
         acc_count_q <= '0;
      end else begin
         data_q      <= data_d;
         valid_q     <= valid_d;
         rr_ptr_q    <= rr_ptr_d;
         acc_count_q <= acc_count_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign rr_ptr    = rr_ptr_q;
   assign acc_count = acc_count_q;

endmodule

// File: tb/tb_demux_1_to_8_buf.sv
// Directed bench for demux_1_to_8_buf: fill, backpressure, round-robin wrap,
// mode switch, asynchronous reset mid-stream and acc_count saturation.
module tb_demux_1_to_8_buf;

   localparam int DATA_W = 8;

   logic                clk;
   logic                rst_n;
   logic [DATA_W-1:0]   in_data;
   logic [2:0]          in_sel;
   logic                auto_mode;
   logic                in_valid;
   logic                in_ready;
   logic [8*DATA_W-1:0] out_data;
   logic [7:0]          out_valid;
   logic [7:0]          out_ready;
   logic [2:0]          rr_ptr;
   logic [15:0]         acc_count;

   int tests_run = 0;
   int tests_failed = 0;

   demux_1_to_8_buf #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .auto_mode (auto_mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rr_ptr    (rr_ptr),
      .acc_count (acc_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      in_data   = '0;
      in_sel    = '0;
      auto_mode = 1'b0;
      in_valid  = 1'b0;
      out_ready = '0;
      #3;
      check("reset_out_valid", 64'(out_valid), 64'h00);
      check("reset_out_data", 64'(out_data), 64'h0);
      check("reset_rr_ptr", 64'(rr_ptr), 64'h0);
      check("reset_acc_count", 64'(acc_count), 64'h0);
      check("reset_in_ready", 64'(in_ready), 64'h1);
      tick();
      rst_n = 1'b1;

      // Manual fill of all eight channels.
      in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_sel  = 3'(k);
         in_data = 8'h10 + 8'(k);
         tick();
      end
      in_valid = 1'b0;
      check("fill_out_valid", 64'(out_valid), 64'hFF);
      check("fill_out_data", 64'(out_data), 64'h1716151413121110);
      check("fill_acc_count", 64'(acc_count), 64'd8);
      check("fill_rr_ptr", 64'(rr_ptr), 64'd0);

      // Backpressure on channel 3, then same-edge replace.
      in_sel   = 3'd3;
      in_data  = 8'hAA;
      in_valid = 1'b1;
      #1;
      check("bp_in_ready_low", 64'(in_ready), 64'h0);
      tick();
      check("bp_lane3_held", 64'(out_data[3*DATA_W +: DATA_W]), 64'h13);
      check("bp_acc_held", 64'(acc_count), 64'd8);
      out_ready = 8'h08;
      #1;
      check("bp_in_ready_high", 64'(in_ready), 64'h1);
      tick();
      in_valid  = 1'b0;
      out_ready = 8'h00;
      check("bp_lane3_new", 64'(out_data[3*DATA_W +: DATA_W]), 64'hAA);
      check("bp_out_valid", 64'(out_valid), 64'hFF);
      check("bp_acc_count", 64'(acc_count), 64'd9);

      // Drain everything; lanes keep their last values.
      out_ready = 8'hFF;
      tick();
      check("drain_out_valid", 64'(out_valid), 64'h00);
      check("drain_lanes_kept", 64'(out_data), 64'h17161514AA121110);

      // Round-robin wrap: ten transfers land on channels 0..7 then 0,1.
      auto_mode = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = 8'(i);
         tick();
         if (i == 0) begin
            check("rr_first_valid", 64'(out_valid), 64'h01);
            check("rr_first_ptr", 64'(rr_ptr), 64'd1);
         end
      end
      in_valid = 1'b0;
      check("rr_wrap_ptr", 64'(rr_ptr), 64'd2);
      check("rr_wrap_acc", 64'(acc_count), 64'd19);
      check("rr_wrap_data", 64'(out_data), 64'h0706050403020908);
      check("rr_wrap_valid", 64'(out_valid), 64'h02);

      // Reset between edges, then the mode-switch scenario from a clean state.
      #2;
      rst_n = 1'b0;
      #1;
      check("rst1_out_valid", 64'(out_valid), 64'h00);
      check("rst1_rr_ptr", 64'(rr_ptr), 64'd0);
      rst_n     = 1'b1;
      out_ready = 8'h00;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'hA0 + 8'(i);
         tick();
      end
      check("mode_auto_ptr", 64'(rr_ptr), 64'd3);
      auto_mode = 1'b0;
      in_sel    = 3'd6;
      out_ready = 8'h40;
      in_data   = 8'hB0;
      tick();
      in_data   = 8'hB1;
      tick();
      check("mode_manual_ptr", 64'(rr_ptr), 64'd3);
      check("mode_lane6", 64'(out_data[6*DATA_W +: DATA_W]), 64'hB1);
      auto_mode = 1'b1;
      out_ready = 8'h00;
      in_data   = 8'hC3;
      tick();
      in_valid = 1'b0;
      check("mode_lane3", 64'(out_data[3*DATA_W +: DATA_W]), 64'hC3);
      check("mode_out_valid", 64'(out_valid), 64'h4F);
      check("mode_rr_ptr", 64'(rr_ptr), 64'd4);
      check("mode_acc_count", 64'(acc_count), 64'd6);

      // Reset mid-stream with channels 0-4 full and rr_ptr=5.
      #2;
      rst_n = 1'b0;
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 8'h50 + 8'(i);
         tick();
      end
      in_valid = 1'b0;
      check("pre_rst_valid", 64'(out_valid), 64'h1F);
      check("pre_rst_ptr", 64'(rr_ptr), 64'd5);
      out_ready = 8'hFF;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst2_out_valid", 64'(out_valid), 64'h00);
      check("rst2_rr_ptr", 64'(rr_ptr), 64'd0);
      check("rst2_acc_count", 64'(acc_count), 64'd0);
      check("rst2_out_data", 64'(out_data), 64'h0);
      check("rst2_in_ready", 64'(in_ready), 64'h1);
      tick();
      check("rst2_held_valid", 64'(out_valid), 64'h00);
      check("rst2_held_data", 64'(out_data), 64'h0);
      rst_n = 1'b1;

      // out_ready on empty channels has no effect.
      tick();
      check("idle_out_valid", 64'(out_valid), 64'h00);
      check("idle_acc_count", 64'(acc_count), 64'd0);

      // Saturation of acc_count.
      in_valid = 1'b1;
      for (int i = 0; i < 65534; i++) begin
         in_data = 8'(i);
         tick();
      end
      check("sat_fffe", 64'(acc_count), 64'hFFFE);
      tick();
      check("sat_ffff", 64'(acc_count), 64'hFFFF);
      tick();
      tick();
      in_valid = 1'b0;
      check("sat_hold", 64'(acc_count), 64'hFFFF);
      check("sat_rr_ptr", 64'(rr_ptr), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/demux_1_to_8_buf.md
DEMUX_1_TO_8_BUF -- requirements
Module: demux_1_to_8_buf

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 8, lane width in bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  source byte.
- in_sel  input  3  destination channel; used only when auto_mode=0.
- auto_mode  input  1  1 = round-robin destination from internal pointer; 0 = in_sel.
- in_valid  input  1  source offers in_data.
- in_ready  output  1  block can accept in_data this cycle.
- out_data  output  8*DATA_W  channel k holding register on bits [k*DATA_W +: DATA_W].
- out_valid  output  8  bit k = channel k register holds unread data.
- out_ready  input  8  bit k = consumer k takes channel k data this cycle.
- rr_ptr  output  3  current round-robin pointer.
- acc_count  output  16  saturating count of accepted input transfers.

Function
REQ-003 The destination channel SHALL be dst = auto_mode ? rr_ptr : in_sel, evaluated combinationally each cycle.
REQ-004 in_ready SHALL be combinational: in_ready = !out_valid[dst] || out_ready[dst].
REQ-005 An input transfer SHALL occur at a rising edge where in_valid && in_ready; only channel dst is written.
REQ-006 On an input transfer, out_data lane dst SHALL load in_data and out_valid[dst] SHALL be 1 from the next cycle (latency 1 cycle).
REQ-007 An output transfer on channel k SHALL occur at a rising edge where out_valid[k] && out_ready[k]; out_valid[k] SHALL clear next cycle unless REQ-008 applies.
REQ-008 When an input and an output transfer hit the same channel at the same edge, out_valid[k] SHALL stay 1 and lane k SHALL hold the new in_data (no bubble, no loss).
REQ-009 Output transfers on different channels SHALL be independent and may all occur at the same edge.
REQ-010 Lane k data SHALL remain stable while out_valid[k]=1 and no input transfer targets k.
REQ-011 out_ready[k] asserted while out_valid[k]=0 SHALL have no effect.
REQ-012 in_valid=1 with in_ready=0 SHALL cause no state change; the source holds in_data and dst.
REQ-013 rr_ptr SHALL increment by 1 modulo 8 (7 -> 0) only on an input transfer with auto_mode=1.
REQ-014 rr_ptr SHALL hold its value in manual mode and across auto_mode changes; switching modes SHALL NOT reset it.
REQ-015 acc_count SHALL increment by 1 on every input transfer in either mode and saturate at 0xFFFF.
REQ-016 Lane contents while out_valid[k]=0 are don't-care for consumers, but SHALL be the last written value (no clearing on read).

Reset
REQ-017 While rst_n=0, regardless of clk, the block SHALL force out_valid=8'h00, out_data=0, rr_ptr=0 and acc_count=0.
REQ-018 During reset in_ready SHALL follow REQ-004 from the reset state, i.e. 1.
REQ-019 Reset mid-operation SHALL discard all held data without generating output transfers; the first edge after deassertion behaves as from the initial state.

Verification
REQ-020 Manual fill: auto_mode=0, out_ready=0, send 0x10..0x17 with in_sel=0..7 -> out_valid=8'hFF, lane k=0x10+k, acc_count=8, rr_ptr=0.
REQ-021 Backpressure: channel 3 full, out_ready[3]=0, in_sel=3, in_data=0xAA -> in_ready=0, lane 3 unchanged; assert out_ready[3] -> same-edge transfer, lane 3=0xAA, out_valid[3] stays 1.
REQ-022 Round-robin wrap: auto_mode=1, out_ready=8'hFF, 10 transfers 0x00..0x09 -> channels 0..7 then 0,1; final rr_ptr=2; lane 1=0x09.
REQ-023 Mode switch: 3 auto transfers (rr_ptr=3), 2 manual to in_sel=6 -> rr_ptr=3, lane 6 holds the 2nd manual byte; next auto transfer lands on channel 3.
REQ-024 Reset mid-stream: channels 0-4 full, rr_ptr=5, pull rst_n low between edges -> out_valid=0, rr_ptr=0, acc_count=0 immediately, no out transfer seen.
REQ-025 Saturation: preload or run 65537 transfers with out_ready=8'hFF -> acc_count=0xFFFF and stays there on further transfers.
